// File: rtl/conv2d_stream_param.sv
// Streaming KxK valid-only 2-D convolution over a raster-order signed pixel stream.
// A pixel is accepted on every clock edge with iValid=1; the result for each complete
// window leaves the pipeline exactly three cycles after the accepting edge.
//
// Ports:
//   iCLK, iRSTn      clock (rising edge), asynchronous active-low reset
//   iClr             synchronous clear of counters, line buffers, window and pipeline
//                    (weights are kept); overrides a simultaneous iValid
//   iValid, iX       pixel strobe and signed pixel data
//   iWren, iADDR, iW weight write port, row-major index r*K+c; indices >= K*K are ignored
//   iShift           arithmetic right shift applied to the full-precision sum
//   oY, oValid       saturated signed result and its valid
//   oSat             result was clipped
//   oFrameDone       pulse with the last result of a frame
module conv2d_stream_param #(
    parameter int unsigned DW    = 8,
    parameter int unsigned WW    = 8,
    parameter int unsigned OW    = 16,
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32,
    parameter int unsigned K     = 5,
    parameter int unsigned AW    = 5
) (
    input  logic                 iCLK,
    input  logic                 iRSTn,
    input  logic                 iClr,
    input  logic                 iValid,
    input  logic signed [DW-1:0] iX,
    input  logic                 iWren,
    input  logic [AW-1:0]        iADDR,
    input  logic signed [WW-1:0] iW,
    input  logic [3:0]           iShift,
    output logic signed [OW-1:0] oY,
    output logic                 oValid,
    output logic                 oSat,
    output logic                 oFrameDone
);

    localparam int unsigned KK   = K * K;
    localparam int unsigned PW   = DW + WW;
    localparam int unsigned ACC  = PW + $clog2(KK);
    localparam int unsigned CMPW = (ACC > OW) ? ACC : OW;
    localparam int unsigned XBW  = $clog2(IMG_W);
    localparam int unsigned YBW  = $clog2(IMG_H);

    localparam logic [XBW-1:0] ColLast  = XBW'(IMG_W - 1);
    localparam logic [XBW-1:0] ColFirst = XBW'(K - 1);
    localparam logic [YBW-1:0] RowLast  = YBW'(IMG_H - 1);
    localparam logic [YBW-1:0] RowFirst = YBW'(K - 1);

    localparam logic signed [CMPW-1:0] YMax = {{(CMPW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [CMPW-1:0] YMin = {{(CMPW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

    logic signed [WW-1:0]  w_q    [KK];
    logic signed [DW-1:0]  lb_q   [K-1][IMG_W];
    logic signed [DW-1:0]  win_q  [KK];
    logic signed [DW-1:0]  col_pix[K];
    logic [XBW-1:0]        col_q;
    logic [YBW-1:0]        row_q;
    logic                  in_window, col_at_end, frame_end;

    logic                  v1_q, last1_q, v2_q, last2_q, v3_q, last3_q;
    logic signed [PW-1:0]  prod_q [KK];
    logic signed [ACC-1:0] sum_q, sum_d, shifted;
    logic signed [CMPW-1:0] s_ext;
    logic [3:0]            shift_q;
    logic signed [OW-1:0]  y_q, y_d;
    logic                  valid_q, sat_q, sat_d, done_q;

    // Weight file: only reset clears it, iClr leaves it alone.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int i = 0; i < KK; i++) w_q[i] <= '0;
        end else if (iWren) begin
            for (int i = 0; i < KK; i++) begin
                if (iADDR == AW'(i)) w_q[i] <= iW;
            end
        end
    end

    // New window column: bottom row is the live pixel, upper rows come from line buffers
    // (lb_q[0] holds the previous row, lb_q[K-2] the oldest).
    always_comb begin
        col_pix[K-1] = iX;
        for (int i = 0; i < K - 1; i++) col_pix[i] = lb_q[K-2-i][col_q];
        col_at_end = (col_q == ColLast);
        frame_end  = col_at_end && (row_q == RowLast);
        in_window  = (row_q >= RowFirst) && (col_q >= ColFirst);
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int l = 0; l < K - 1; l++) begin
                for (int x = 0; x < IMG_W; x++) lb_q[l][x] <= '0;
            end
            for (int i = 0; i < KK; i++) win_q[i] <= '0;
            col_q   <= '0;
            row_q   <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
        end else if (iClr) begin
            for (int l = 0; l < K - 1; l++) begin
                for (int x = 0; x < IMG_W; x++) lb_q[l][x] <= '0;
            end
            for (int i = 0; i < KK; i++) win_q[i] <= '0;
            col_q   <= '0;
            row_q   <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            v1_q    <= iValid && in_window;
            last1_q <= iValid && frame_end;
            if (iValid) begin
                lb_q[0][col_q] <= iX;
                for (int l = 1; l < K - 1; l++) lb_q[l][col_q] <= lb_q[l-1][col_q];
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++) win_q[i*K+j] <= win_q[i*K+j+1];
                    win_q[i*K+K-1] <= col_pix[i];
                end
                if (col_at_end) begin
                    col_q <= '0;
                    row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < KK; i++) sum_d = sum_d + ACC'(prod_q[i]);
    end

    always_comb begin
        shifted = sum_q >>> shift_q;
        s_ext   = CMPW'(shifted);
        y_d     = s_ext[OW-1:0];
        sat_d   = 1'b0;
        if (s_ext > YMax) begin
            y_d   = YMax[OW-1:0];
            sat_d = 1'b1;
        end else if (s_ext < YMin) begin
            y_d   = YMin[OW-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int i = 0; i < KK; i++) prod_q[i] <= '0;
            {v2_q, last2_q, v3_q, last3_q} <= '0;
            sum_q   <= '0;
            shift_q <= '0;
            y_q     <= '0;
            {valid_q, sat_q, done_q} <= '0;
        end else if (iClr) begin
            for (int i = 0; i < KK; i++) prod_q[i] <= '0;
            {v2_q, last2_q, v3_q, last3_q} <= '0;
            sum_q   <= '0;
            shift_q <= '0;
            y_q     <= '0;
            {valid_q, sat_q, done_q} <= '0;
        end else begin
            for (int i = 0; i < KK; i++) prod_q[i] <= PW'(win_q[i]) * PW'(w_q[i]);
            v2_q    <= v1_q;
            last2_q <= last1_q;
            sum_q   <= sum_d;
            shift_q <= iShift;
            v3_q    <= v2_q;
            last3_q <= last2_q;
            valid_q <= v3_q;
            y_q     <= v3_q ? y_d : '0;
            sat_q   <= v3_q && sat_d;
            done_q  <= v3_q && last3_q;
        end
    end

    assign oY         = y_q;
    assign oValid     = valid_q;
    assign oSat       = sat_q;
    assign oFrameDone = done_q;

endmodule
